mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache 8-word block fills onto a single main-memory read port.
// Optional feature: define MEM_ARB_RR_EN for round-robin on simultaneous misses (default: D over I).
module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  issue_cnt;
  logic [2:0]  rcv_cnt;
  logic [2:0]  issue_nxt;
  logic [15:0] base;
  logic [15:0] grant_base;
  logic        grant_d;
  logic        grant_i;

  // Responses are counted rather than timed, but a zero latency would make no sense.
  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("mem_arbiter: MEM_LATENCY must be at least 1");
  end

`ifdef MEM_ARB_RR_EN
  logic prefer_d;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_miss && i_miss) begin
      grant_d = prefer_d;
      grant_i = !prefer_d;
    end else begin
      grant_d = d_miss;
      grant_i = i_miss;
    end
  end
`else
  always_comb begin
    grant_d = d_miss;
    grant_i = i_miss && !d_miss;
  end
`endif

  assign grant_base = grant_d ? {d_miss_addr[15:4], 4'h0} : {i_miss_addr[15:4], 4'h0};
  assign issue_nxt  = issue_cnt + 3'd1;

  // Fill writes track the returning data in the same cycle, so they stay combinational.
  assign fill_data = mem_data;
  assign fill_word = rcv_cnt;
  assign i_fill_we = (state == I_FILL) && mem_data_valid;
  assign d_fill_we = (state == D_FILL) && mem_data_valid;
  assign i_done    = i_fill_we && (rcv_cnt == 3'd7);
  assign d_done    = d_fill_we && (rcv_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= 3'd0;
      rcv_cnt   <= 3'd0;
      base      <= 16'h0000;
      mem_en    <= 1'b0;
      mem_addr  <= 16'h0000;
`ifdef MEM_ARB_RR_EN
      prefer_d  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            state     <= grant_d ? D_FILL : I_FILL;
            base      <= grant_base;
            mem_addr  <= grant_base;
            mem_en    <= 1'b1;
            issue_cnt <= 3'd0;
            rcv_cnt   <= 3'd0;
`ifdef MEM_ARB_RR_EN
            prefer_d  <= !grant_d;
`endif
          end
        end
        default: begin
          // Issue side: eight back-to-back reads, then hold off until the block returns.
          if (mem_en) begin
            if (issue_cnt == 3'd7) begin
              mem_en <= 1'b0;
            end else begin
              issue_cnt <= issue_nxt;
              mem_addr  <= base + {12'd0, issue_nxt, 1'b0};
            end
          end
          if (mem_data_valid) begin
            if (rcv_cnt == 3'd7) begin
              state     <= IDLE;
              rcv_cnt   <= 3'd0;
              issue_cnt <= 3'd0;
              mem_en    <= 1'b0;
            end else begin
              rcv_cnt <= rcv_cnt + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency in-order memory, caches that drop requests on done,
// and a transaction-level reference model of the block fill.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done;

  mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory environment
  bit          pv [LAT];
  logic [15:0] pa [LAT];
  bit          out_v;
  logic [15:0] out_a;
  logic [15:0] salt;
  bit          inj;

  // Reference model: the block transaction currently in flight
  bit          m_active;
  bit          m_owner_d;
  logic [15:0] m_base;
  int          m_issued, m_recv;
  bit          m_addr_zero;
  bit          m_ptr_d;
  int          m_dcomp, m_icomp;
  bit          exp_q [$];

  // Observations of the DUT
  logic        s_en;
  logic [15:0] s_addr;
  bit          s_ddone, s_idone;
  int          d_dones, i_dones;
  bit          done_q [$];
  logic [15:0] addr_q [$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd40503) ^ salt;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_owner_d = 0; m_base = '0; m_issued = 0; m_recv = 0;
    m_addr_zero = 1; m_ptr_d = 1;
    for (int k = 0; k < LAT; k++) begin pv[k] = 0; pa[k] = '0; end
    out_v = 0;
  endtask

  task automatic cycle();
    bit exp_en, exp_dwe, exp_iwe, gd, gi;
    logic [2:0] exp_word;
    @(negedge clk);
    s_en = mem_en; s_addr = mem_addr; s_ddone = (d_done === 1'b1); s_idone = (i_done === 1'b1);
    if (s_ddone) begin d_dones++; done_q.push_back(1'b1); end
    if (s_idone) begin i_dones++; done_q.push_back(1'b0); end
    if (mem_en === 1'b1) addr_q.push_back(mem_addr);
    exp_en   = m_active && (m_issued < 8);
    exp_dwe  = m_active && m_owner_d && mem_data_valid;
    exp_iwe  = m_active && !m_owner_d && mem_data_valid;
    exp_word = m_active ? 3'(m_recv) : 3'd0;
    check("mem_en", {15'd0, mem_en}, {15'd0, exp_en});
    if (exp_en) check("mem_addr", mem_addr, m_base + 16'(2 * m_issued));
    else if (m_addr_zero) check("mem_addr_rst", mem_addr, 16'h0000);
    check("fill_word", {13'd0, fill_word}, {13'd0, exp_word});
    check("d_fill_we", {15'd0, d_fill_we}, {15'd0, exp_dwe});
    check("i_fill_we", {15'd0, i_fill_we}, {15'd0, exp_iwe});
    check("d_done", {15'd0, d_done}, {15'd0, exp_dwe && (m_recv == 7)});
    check("i_done", {15'd0, i_done}, {15'd0, exp_iwe && (m_recv == 7)});
    if (exp_dwe || exp_iwe) check("fill_data", fill_data, mem_word(m_base + 16'(2 * m_recv)));

    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      out_v = pv[LAT-1]; out_a = pa[LAT-1];
      for (int k = LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
      pv[0] = (s_en === 1'b1); pa[0] = s_addr;
      if (m_active) begin
        if (m_issued < 8) m_issued++;
        if (mem_data_valid) begin
          m_recv++;
          if (m_recv == 8) begin
            m_active = 0; m_recv = 0; m_issued = 0;
            exp_q.push_back(m_owner_d);
            if (m_owner_d) m_dcomp++; else m_icomp++;
          end
        end
      end else begin
`ifdef MEM_ARB_RR_EN
        gd = (d_miss && i_miss) ? m_ptr_d : d_miss;
        gi = i_miss && !gd;
        if (gd || gi) m_ptr_d = !gd;
`else
        gd = d_miss;
        gi = i_miss && !d_miss;
`endif
        if (gd || gi) begin
          m_active = 1; m_owner_d = gd; m_issued = 0; m_recv = 0; m_addr_zero = 0;
          m_base = (gd ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        end
      end
    end

    #1;
    if (out_v) begin
      mem_data_valid = 1'b1; mem_data = mem_word(out_a);
    end else if (inj) begin
      mem_data_valid = 1'b1; mem_data = 16'($urandom); inj = 0;
    end else begin
      mem_data_valid = 1'b0; mem_data = 16'($urandom);
    end
    if (s_ddone) d_miss = 1'b0;
    if (s_idone) i_miss = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit scramble);
    int n = 0;
    while ((m_active || d_miss || i_miss) && n < budget) begin
      cycle();
      n++;
      if (scramble && $urandom_range(0, 9) == 0) begin
        d_miss_addr = 16'($urandom); i_miss_addr = 16'($urandom);
      end
    end
    check({tag, "_timeout"}, {15'd0, (m_active || d_miss || i_miss)}, 16'd0);
    cycle();
  endtask

  task automatic check_order(input string tag);
    check({tag, "_done_cnt"}, 16'(done_q.size()), 16'(exp_q.size()));
    for (int k = 0; k < done_q.size() && k < exp_q.size(); k++)
      check({tag, "_done_order"}, {15'd0, done_q[k]}, {15'd0, exp_q[k]});
  endtask

  initial begin
    int d0, i0, n;
    bit [1:0] r;
    salt = 16'($urandom);
    rst_n = 1'b0; i_miss = 0; d_miss = 0; i_miss_addr = '0; d_miss_addr = '0;
    mem_data = '0; mem_data_valid = 0; inj = 0;
    d_dones = 0; i_dones = 0; m_dcomp = 0; m_icomp = 0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Single D miss at 0x1236
    d0 = d_dones; i0 = i_dones; addr_q.delete();
    d_miss_addr = 16'h1236; d_miss = 1;
    wait_idle("d_basic", 100, 0);
    check("d_basic_dones", 16'(d_dones - d0), 16'd1);
    check("d_basic_idones", 16'(i_dones - i0), 16'd0);
    check("d_basic_nreq", 16'(addr_q.size()), 16'd8);
    if (addr_q.size() == 8) begin
      check("d_basic_first", addr_q[0], 16'h1230);
      check("d_basic_last", addr_q[7], 16'h123E);
    end

    // Block at top of address space
    addr_q.delete();
    d_miss_addr = 16'hFFFA; d_miss = 1;
    wait_idle("d_top", 100, 0);
    check("d_top_nreq", 16'(addr_q.size()), 16'd8);
    if (addr_q.size() == 8) begin
      check("d_top_first", addr_q[0], 16'hFFF0);
      check("d_top_last", addr_q[7], 16'hFFFE);
    end

    // Simultaneous I and D misses
    done_q.delete(); exp_q.delete();
    d_miss_addr = 16'($urandom); i_miss_addr = 16'($urandom);
    d_miss = 1; i_miss = 1;
    wait_idle("pair", 200, 0);
    check_order("pair");
`ifndef MEM_ARB_RR_EN
    if (done_q.size() == 2) begin
      check("pair_first_is_d", {15'd0, done_q[0]}, 16'd1);
      check("pair_second_is_i", {15'd0, done_q[1]}, 16'd0);
    end
`endif

    // Reset after the third returned word aborts the fill
    d0 = d_dones;
    d_miss_addr = 16'($urandom); d_miss = 1;
    n = 0;
    while (m_recv != 3 && n < 50) begin cycle(); n++; end
    check("abort_reach3", 16'(m_recv), 16'd3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("abort_no_done", 16'(d_dones - d0), 16'd0);
    wait_idle("abort_refill", 100, 0);
    check("abort_refill_done", 16'(d_dones - d0), 16'd1);

    // Spurious valids while idle
    d0 = d_dones; i0 = i_dones;
    repeat (3) begin inj = 1; cycle(); cycle(); end
    check("idle_valid_d", 16'(d_dones - d0), 16'd0);
    check("idle_valid_i", 16'(i_dones - i0), 16'd0);

    // Request dropped and address changed mid-fill
    d0 = d_dones;
    d_miss_addr = 16'($urandom); d_miss = 1;
    n = 0;
    while (m_issued != 3 && n < 20) begin cycle(); n++; end
    d_miss = 0; d_miss_addr = 16'($urandom);
    wait_idle("drop", 100, 0);
    check("drop_done", 16'(d_dones - d0), 16'd1);

    // Randomized traffic
    done_q.delete(); exp_q.delete();
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom);
      d_miss_addr = 16'($urandom); i_miss_addr = 16'($urandom);
      if (r == 2'b00) inj = $urandom_range(0, 1) == 1;
      repeat ($urandom_range(0, 2)) cycle();
      d_miss = r[0]; i_miss = r[1];
      wait_idle("rand", 200, 1);
    end
    check_order("rand");

    check("total_d", 16'(d_dones), 16'(m_dcomp));
    check("total_i", 16'(i_dones), 16'(m_icomp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
